// File: rtl/alu_reservation_station.sv
// alu_reservation_station
//
// Reservation station in front of the ALU. Dispatched ALU, branch and JALR ops
// are held here until both operands are available. Missing operands are filled
// in by snooping the common data bus (CDB). The oldest fully-ready op goes to
// a registered valid/ready output stage.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   flush_i                 synchronous flush of all entries and the output stage
//   dispatch_*              dispatch request (valid/ready) with opcode, operands
//                           (value, valid, producer tag), immediate, pc, dest tag
//   cdb_valid_i/tag_i/value_i  result broadcast snooped for operand wakeup
//   issue_valid_o/ready_i   output stage handshake toward the ALU
//   issue_*_o               fields of the op held in the output stage
module alu_reservation_station #(
    parameter int DatapathWidth     = 32,
    parameter int AluOperationWidth = 5,
    parameter int TagWidth          = 3,
    parameter int NumEntries        = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,

    input  logic                         dispatch_valid_i,
    output logic                         dispatch_ready_o,
    input  logic [AluOperationWidth-1:0] dispatch_operation_i,
    input  logic [DatapathWidth-1:0]     dispatch_op1_i,
    input  logic                         dispatch_op1_valid_i,
    input  logic [TagWidth-1:0]          dispatch_op1_tag_i,
    input  logic [DatapathWidth-1:0]     dispatch_op2_i,
    input  logic                         dispatch_op2_valid_i,
    input  logic [TagWidth-1:0]          dispatch_op2_tag_i,
    input  logic [DatapathWidth-1:0]     dispatch_immediate_i,
    input  logic [DatapathWidth-1:0]     dispatch_pc_i,
    input  logic [TagWidth-1:0]          dispatch_dest_tag_i,

    input  logic                         cdb_valid_i,
    input  logic [TagWidth-1:0]          cdb_tag_i,
    input  logic [DatapathWidth-1:0]     cdb_value_i,

    output logic                         issue_valid_o,
    input  logic                         issue_ready_i,
    output logic [AluOperationWidth-1:0] issue_operation_o,
    output logic [DatapathWidth-1:0]     issue_operand1_o,
    output logic [DatapathWidth-1:0]     issue_operand2_o,
    output logic [DatapathWidth-1:0]     issue_immediate_o,
    output logic [DatapathWidth-1:0]     issue_pc_o,
    output logic [TagWidth-1:0]          issue_dest_tag_o
);

    localparam logic [NumEntries-1:0] OneLsb = {{(NumEntries-1){1'b0}}, 1'b1};

    // Per-entry state gathered from the generate blocks.
    logic [NumEntries-1:0]        busy_vec;
    logic [NumEntries-1:0]        ready_vec;
    logic [NumEntries-1:0]        alloc_vec;
    logic [NumEntries-1:0]        issue_sel_vec;
    logic [NumEntries-1:0]        issue_take_vec;
    logic [AluOperationWidth-1:0] entry_operation [NumEntries];
    logic [DatapathWidth-1:0]     entry_op1       [NumEntries];
    logic [DatapathWidth-1:0]     entry_op2       [NumEntries];
    logic [DatapathWidth-1:0]     entry_imm       [NumEntries];
    logic [DatapathWidth-1:0]     entry_pc        [NumEntries];
    logic [TagWidth-1:0]          entry_dest      [NumEntries];

    logic                         dispatch_fire;
    logic                         issue_load;

    // Operand values as they will be written on dispatch, with the CDB bypass.
    logic                         disp_op1_wake, disp_op2_wake;
    logic                         disp_op1_valid, disp_op2_valid;
    logic [DatapathWidth-1:0]     disp_op1_value, disp_op2_value;

    // Output stage registers.
    logic                         issue_valid_reg;
    logic [AluOperationWidth-1:0] issue_operation_reg;
    logic [DatapathWidth-1:0]     issue_operand1_reg;
    logic [DatapathWidth-1:0]     issue_operand2_reg;
    logic [DatapathWidth-1:0]     issue_immediate_reg;
    logic [DatapathWidth-1:0]     issue_pc_reg;
    logic [TagWidth-1:0]          issue_dest_tag_reg;

    // Fields of the selected entry.
    logic [AluOperationWidth-1:0] sel_operation;
    logic [DatapathWidth-1:0]     sel_op1, sel_op2, sel_imm, sel_pc;
    logic [TagWidth-1:0]          sel_dest;

    assign dispatch_ready_o = |(~busy_vec);
    assign dispatch_fire    = dispatch_valid_i && dispatch_ready_o;

    // Lowest free index: x & -x with x = ~busy, and -x = busy + 1.
    assign alloc_vec = (~busy_vec) & (busy_vec + OneLsb);

    assign disp_op1_wake  = !dispatch_op1_valid_i && cdb_valid_i && (dispatch_op1_tag_i == cdb_tag_i);
    assign disp_op2_wake  = !dispatch_op2_valid_i && cdb_valid_i && (dispatch_op2_tag_i == cdb_tag_i);
    assign disp_op1_valid = dispatch_op1_valid_i || disp_op1_wake;
    assign disp_op2_valid = dispatch_op2_valid_i || disp_op2_wake;
    assign disp_op1_value = disp_op1_wake ? cdb_value_i : dispatch_op1_i;
    assign disp_op2_value = disp_op2_wake ? cdb_value_i : dispatch_op2_i;

    assign issue_load     = (!issue_valid_reg || issue_ready_i) && (|ready_vec);
    assign issue_take_vec = issue_sel_vec & {NumEntries{issue_load}};

    for (genvar gi = 0; gi < NumEntries; gi++) begin : g_entry
        logic                         busy_reg;
        logic                         op1_valid_reg, op2_valid_reg;
        logic [AluOperationWidth-1:0] operation_reg;
        logic [DatapathWidth-1:0]     op1_reg, op2_reg, imm_reg, pc_reg;
        logic [TagWidth-1:0]          op1_tag_reg, op2_tag_reg, dest_reg;
        // age_reg[j] set means this entry is older than entry j.
        logic [NumEntries-1:0]        age_reg;
        logic                         alloc;
        logic                         op1_wake, op2_wake;

        assign alloc    = dispatch_fire && alloc_vec[gi];
        assign op1_wake = busy_reg && !op1_valid_reg && cdb_valid_i && (op1_tag_reg == cdb_tag_i);
        assign op2_wake = busy_reg && !op2_valid_reg && cdb_valid_i && (op2_tag_reg == cdb_tag_i);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                busy_reg      <= 1'b0;
                op1_valid_reg <= 1'b0;
                op2_valid_reg <= 1'b0;
                operation_reg <= '0;
                op1_reg       <= '0;
                op2_reg       <= '0;
                imm_reg       <= '0;
                pc_reg        <= '0;
                op1_tag_reg   <= '0;
                op2_tag_reg   <= '0;
                dest_reg      <= '0;
                age_reg       <= '0;
            end else if (flush_i) begin
                busy_reg      <= 1'b0;
                op1_valid_reg <= 1'b0;
                op2_valid_reg <= 1'b0;
            end else if (alloc) begin
                busy_reg      <= 1'b1;
                operation_reg <= dispatch_operation_i;
                op1_reg       <= disp_op1_value;
                op1_valid_reg <= disp_op1_valid;
                op1_tag_reg   <= dispatch_op1_tag_i;
                op2_reg       <= disp_op2_value;
                op2_valid_reg <= disp_op2_valid;
                op2_tag_reg   <= dispatch_op2_tag_i;
                imm_reg       <= dispatch_immediate_i;
                pc_reg        <= dispatch_pc_i;
                dest_reg      <= dispatch_dest_tag_i;
                // The new entry is younger than everyone.
                age_reg       <= '0;
            end else begin
                if (issue_take_vec[gi]) begin
                    busy_reg <= 1'b0;
                end
                if (op1_wake) begin
                    op1_reg       <= cdb_value_i;
                    op1_valid_reg <= 1'b1;
                end
                if (op2_wake) begin
                    op2_reg       <= cdb_value_i;
                    op2_valid_reg <= 1'b1;
                end
                // Whoever is being allocated elsewhere becomes younger than us.
                if (dispatch_fire) begin
                    age_reg <= age_reg | alloc_vec;
                end
            end
        end

        assign busy_vec[gi]  = busy_reg;
        assign ready_vec[gi] = busy_reg && op1_valid_reg && op2_valid_reg;
        // Oldest ready: older than every other ready entry (self bit forced).
        assign issue_sel_vec[gi] = ready_vec[gi] && (&(age_reg | ~ready_vec | (OneLsb << gi)));

        assign entry_operation[gi] = operation_reg;
        assign entry_op1[gi]       = op1_reg;
        assign entry_op2[gi]       = op2_reg;
        assign entry_imm[gi]       = imm_reg;
        assign entry_pc[gi]        = pc_reg;
        assign entry_dest[gi]      = dest_reg;
    end

    // issue_sel_vec is one-hot or zero, so a simple scan is enough.
    always_comb begin
        sel_operation = '0;
        sel_op1       = '0;
        sel_op2       = '0;
        sel_imm       = '0;
        sel_pc        = '0;
        sel_dest      = '0;
        for (int i = 0; i < NumEntries; i++) begin
            if (issue_sel_vec[i]) begin
                sel_operation = entry_operation[i];
                sel_op1       = entry_op1[i];
                sel_op2       = entry_op2[i];
                sel_imm       = entry_imm[i];
                sel_pc        = entry_pc[i];
                sel_dest      = entry_dest[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issue_valid_reg     <= 1'b0;
            issue_operation_reg <= '0;
            issue_operand1_reg  <= '0;
            issue_operand2_reg  <= '0;
            issue_immediate_reg <= '0;
            issue_pc_reg        <= '0;
            issue_dest_tag_reg  <= '0;
        end else if (flush_i) begin
            issue_valid_reg <= 1'b0;
        end else if (issue_load) begin
            issue_valid_reg     <= 1'b1;
            issue_operation_reg <= sel_operation;
            issue_operand1_reg  <= sel_op1;
            issue_operand2_reg  <= sel_op2;
            issue_immediate_reg <= sel_imm;
            issue_pc_reg        <= sel_pc;
            issue_dest_tag_reg  <= sel_dest;
        end else if (issue_ready_i) begin
            issue_valid_reg <= 1'b0;
        end
    end

    assign issue_valid_o     = issue_valid_reg;
    assign issue_operation_o = issue_operation_reg;
    assign issue_operand1_o  = issue_operand1_reg;
    assign issue_operand2_o  = issue_operand2_reg;
    assign issue_immediate_o = issue_immediate_reg;
    assign issue_pc_o        = issue_pc_reg;
    assign issue_dest_tag_o  = issue_dest_tag_reg;

endmodule
